// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: "value present" tag marker, entry states and opcodes.
package tomasulo_pkg;

  // All-ones tag marks an operand whose value is already held; users slice it to TAG_W.
  localparam logic [31:0] NO_TAG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } ent_state_e;

  localparam logic [2:0] OP_SOM = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

endpackage

// File: rtl/reservation_station_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module age_select #(
  parameter int ENTRIES = 3
) (
  input  logic [ENTRIES-1:0]         ready,
  input  logic [ENTRIES*ENTRIES-1:0] older,  // older[i*ENTRIES+j]: entry i was dispatched before j
  output logic [ENTRIES-1:0]         grant
);

  // An entry wins when it is ready and no ready entry predates it; the age order is total.
  always_comb begin
    grant = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older[j*ENTRIES+i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until operands arrive, issues oldest-ready first,
// frees an entry when its own result appears on the common data bus.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int ENTRIES    = 3,
  parameter int TAG_W      = 4,
  parameter int STATION_ID = 0,
  parameter int OP_W       = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [2:0]                   disp_dst,
  input  logic [DATA_W-1:0]            disp_vj,
  input  logic [DATA_W-1:0]            disp_vk,
  input  logic [TAG_W-1:0]             disp_qj,
  input  logic [TAG_W-1:0]             disp_qk,
  output logic [TAG_W-1:0]             disp_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [OP_W-1:0]              iss_op,
  output logic [DATA_W-1:0]            iss_a,
  output logic [DATA_W-1:0]            iss_b,
  output logic [2:0]                   iss_dst,
  output logic [TAG_W-1:0]             iss_tag,
  output logic [$clog2(ENTRIES+1)-1:0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam logic [TAG_W-1:0] NO_T = NO_TAG[TAG_W-1:0];

  function automatic logic [TAG_W-1:0] own_tag(input int idx);
    return TAG_W'(STATION_ID*ENTRIES + idx);
  endfunction

  ent_state_e        state_q [ENTRIES];
  ent_state_e        state_d [ENTRIES];
  logic [TAG_W-1:0]  qj_q [ENTRIES], qj_d [ENTRIES];
  logic [TAG_W-1:0]  qk_q [ENTRIES], qk_d [ENTRIES];
  logic [DATA_W-1:0] vj_q [ENTRIES], vj_d [ENTRIES];
  logic [DATA_W-1:0] vk_q [ENTRIES], vk_d [ENTRIES];
  logic [OP_W-1:0]   op_q [ENTRIES], op_d [ENTRIES];
  logic [2:0]        dst_q [ENTRIES], dst_d [ENTRIES];
  logic [ENTRIES-1:0] age_q [ENTRIES], age_d [ENTRIES];  // age_q[i][j]: i is older than j
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;

  logic [ENTRIES-1:0]         ready_vec, grant, alloc_oh;
  logic [ENTRIES*ENTRIES-1:0] older_flat;
  logic                       disp_fire, iss_fire;

  // Lowest free slot is the allocation target; also flatten state for the age picker.
  always_comb begin
    alloc_oh   = '0;
    disp_ready = 1'b0;
    disp_tag   = '0;
    ready_vec  = '0;
    older_flat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready_vec[i] = (state_q[i] == ST_READY);
      for (int j = 0; j < ENTRIES; j++) older_flat[i*ENTRIES+j] = age_q[i][j];
      if (!disp_ready && state_q[i] == ST_FREE) begin
        disp_ready  = 1'b1;
        alloc_oh[i] = 1'b1;
        disp_tag    = own_tag(i);
      end
    end
  end

  age_select #(.ENTRIES(ENTRIES)) u_age_select (
    .ready (ready_vec),
    .older (older_flat),
    .grant (grant)
  );

  assign iss_valid = |ready_vec;
  assign iss_fire  = iss_valid && iss_ready;
  assign disp_fire = disp_valid && disp_ready;

  // Issue outputs are an AND-OR mux on the one-hot grant, so they read zero when nothing is ready.
  always_comb begin
    iss_op  = '0;
    iss_a   = '0;
    iss_b   = '0;
    iss_dst = '0;
    iss_tag = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      iss_op  = iss_op  | ({OP_W{grant[i]}}   & op_q[i]);
      iss_a   = iss_a   | ({DATA_W{grant[i]}} & vj_q[i]);
      iss_b   = iss_b   | ({DATA_W{grant[i]}} & vk_q[i]);
      iss_dst = iss_dst | ({3{grant[i]}}      & dst_q[i]);
      iss_tag = iss_tag | ({TAG_W{grant[i]}}  & own_tag(i));
    end
  end

  // Per-entry next state: CDB wakeup, issue, completion, then allocation of the free slot.
  always_comb begin
    logic byp_j, byp_k;
    byp_j = cdb_valid && (disp_qj != NO_T) && (cdb_tag == disp_qj);
    byp_k = cdb_valid && (disp_qk != NO_T) && (cdb_tag == disp_qk);
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
      op_d[i]    = op_q[i];
      dst_d[i]   = dst_q[i];
      age_d[i]   = age_q[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      case (state_q[i])
        ST_WAIT: begin
          if (cdb_valid && qj_q[i] != NO_T && qj_q[i] == cdb_tag) begin
            qj_d[i] = NO_T;
            vj_d[i] = cdb_data;
          end
          if (cdb_valid && qk_q[i] != NO_T && qk_q[i] == cdb_tag) begin
            qk_d[i] = NO_T;
            vk_d[i] = cdb_data;
          end
          if (qj_d[i] == NO_T && qk_d[i] == NO_T) state_d[i] = ST_READY;
        end
        ST_READY: if (iss_fire && grant[i]) state_d[i] = ST_EXEC;
        ST_EXEC:  if (cdb_valid && cdb_tag == own_tag(i)) state_d[i] = ST_FREE;
        default: ;
      endcase
    end
    if (disp_fire) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_oh[i]) begin
          op_d[i]    = disp_op;
          dst_d[i]   = disp_dst;
          qj_d[i]    = byp_j ? NO_T : disp_qj;
          qk_d[i]    = byp_k ? NO_T : disp_qk;
          vj_d[i]    = byp_j ? cdb_data : disp_vj;
          vk_d[i]    = byp_k ? cdb_data : disp_vk;
          state_d[i] = (qj_d[i] == NO_T && qk_d[i] == NO_T) ? ST_READY : ST_WAIT;
          // Newest entry: older than nobody, younger than everyone else.
          age_d[i] = '0;
          for (int j = 0; j < ENTRIES; j++) begin
            if (j != i) age_d[j][i] = 1'b1;
          end
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state_d[i] != ST_FREE) count_d = count_d + CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(ENTRIES));
    empty_d = (count_d == '0);
  end

  // Control state: reset beats flush, flush beats all traffic of the cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        qj_q[i]    <= NO_T;
        qk_q[i]    <= NO_T;
        age_q[i]   <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_FREE;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        age_q[i]   <= age_d[i];
      end
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Payload fields carry no reset; they are only observed through a granted, valid entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      vj_q[i]  <= vj_d[i];
      vk_q[i]  <= vk_d[i];
      op_q[i]  <= op_d[i];
      dst_q[i] <= dst_d[i];
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a slot-level behavioural model and per-cycle compare.
module tb_reservation_station;
  import tomasulo_pkg::*;

  localparam int DATA_W = 9, ENTRIES = 3, TAG_W = 4, STATION_ID = 0, OP_W = 3;
  localparam logic [3:0] NT = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, disp_valid, disp_ready, cdb_valid, iss_valid, iss_ready, full, empty;
  logic [OP_W-1:0] disp_op, iss_op;
  logic [2:0] disp_dst, iss_dst;
  logic [DATA_W-1:0] disp_vj, disp_vk, cdb_data, iss_a, iss_b;
  logic [TAG_W-1:0] disp_qj, disp_qk, disp_tag, cdb_tag, iss_tag;
  logic [1:0] count;

  reservation_station #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W),
                        .STATION_ID(STATION_ID), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dst(disp_dst),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
    .iss_dst(iss_dst), .iss_tag(iss_tag), .count(count), .full(full), .empty(empty)
  );

  // Model: each slot is occupied or not, issued or not, with pending flags per operand
  // and a dispatch sequence number that defines age.
  typedef struct {
    bit         occ, issued, pj, pk;
    logic [3:0] tj, tk;
    logic [8:0] vj, vk;
    logic [2:0] op, dst;
    int         seq;
  } slot_t;

  slot_t m  [ENTRIES];
  slot_t mn [ENTRIES];
  int seq_ctr = 0;
  int n_cmp = 0, n_bad = 0;
  bit model_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] slot_tag(input int i);
    return 4'(STATION_ID*ENTRIES + i);
  endfunction

  function automatic int oldest();
    int s = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m[i].occ && !m[i].issued && !m[i].pj && !m[i].pk && (s < 0 || m[i].seq < m[s].seq)) s = i;
    return s;
  endfunction

  function automatic int first_free();
    int f = -1;
    for (int i = 0; i < ENTRIES; i++) if (!m[i].occ && f < 0) f = i;
    return f;
  endfunction

  task automatic model_next();
    int sel, fs;
    bit bj, bk;
    mn = m;
    if (!rst_n || flush) begin
      for (int i = 0; i < ENTRIES; i++) mn[i].occ = 1'b0;
    end else begin
      sel = oldest();
      fs  = first_free();
      for (int i = 0; i < ENTRIES; i++) if (m[i].occ) begin
        if (cdb_valid && m[i].pj && m[i].tj == cdb_tag) begin mn[i].pj = 1'b0; mn[i].vj = cdb_data; end
        if (cdb_valid && m[i].pk && m[i].tk == cdb_tag) begin mn[i].pk = 1'b0; mn[i].vk = cdb_data; end
        if (m[i].issued && cdb_valid && cdb_tag == slot_tag(i)) mn[i].occ = 1'b0;
      end
      if (sel >= 0 && iss_ready) mn[sel].issued = 1'b1;
      if (disp_valid && fs >= 0) begin
        bj = (disp_qj != NT) && cdb_valid && (cdb_tag == disp_qj);
        bk = (disp_qk != NT) && cdb_valid && (cdb_tag == disp_qk);
        mn[fs].occ = 1'b1; mn[fs].issued = 1'b0;
        mn[fs].op = disp_op; mn[fs].dst = disp_dst;
        mn[fs].tj = disp_qj; mn[fs].tk = disp_qk;
        mn[fs].pj = (disp_qj != NT) && !bj;
        mn[fs].pk = (disp_qk != NT) && !bk;
        mn[fs].vj = bj ? cdb_data : disp_vj;
        mn[fs].vk = bk ? cdb_data : disp_vk;
        mn[fs].seq = seq_ctr;
        seq_ctr++;
      end
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    m = mn;
    model_live = 1'b1;
    #1;
  endtask

  task automatic set_disp(input logic [2:0] op, input logic [2:0] dst, input logic [8:0] vj,
                          input logic [8:0] vk, input logic [3:0] qj, input logic [3:0] qk);
    disp_valid = 1'b1; disp_op = op; disp_dst = dst;
    disp_vj = vj; disp_vk = vk; disp_qj = qj; disp_qk = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [8:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  // Every cycle: outputs against the model state that holds after the last edge.
  always @(negedge clk) begin
    int s, c, ff;
    if (model_live) begin
      s = oldest(); ff = first_free(); c = 0;
      for (int i = 0; i < ENTRIES; i++) if (m[i].occ) c++;
      chk("m_iss_valid", iss_valid, (s >= 0));
      if (s >= 0) begin
        chk("m_iss_a", iss_a, m[s].vj);
        chk("m_iss_b", iss_b, m[s].vk);
        chk("m_iss_op", iss_op, m[s].op);
        chk("m_iss_dst", iss_dst, m[s].dst);
        chk("m_iss_tag", iss_tag, slot_tag(s));
      end
      chk("m_count", count, c);
      chk("m_full", full, (c == ENTRIES));
      chk("m_empty", empty, (c == 0));
      chk("m_disp_ready", disp_ready, (ff >= 0));
      if (ff >= 0) chk("m_disp_tag", disp_tag, slot_tag(ff));
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_dst = '0;
    disp_vj = '0; disp_vk = '0; disp_qj = NT; disp_qk = NT;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; iss_ready = 1'b0;
    step(); step();
    chk("rst_count", count, 0);     chk("rst_empty", empty, 1);   chk("rst_full", full, 0);
    chk("rst_iss_valid", iss_valid, 0); chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_a", iss_a, 0); chk("rst_iss_b", iss_b, 0); chk("rst_iss_tag", iss_tag, 0);
    chk("rst_iss_op", iss_op, 0); chk("rst_disp_tag", disp_tag, 0);
    rst_n = 1'b1;

    // Ready dispatch issues the next cycle
    set_disp(OP_SOM, 3'd2, 9'd5, 9'd3, NT, NT); iss_ready = 1'b1; step(); idle();
    chk("rdy_iss_valid", iss_valid, 1); chk("rdy_iss_a", iss_a, 5); chk("rdy_iss_b", iss_b, 3);
    chk("rdy_iss_tag", iss_tag, 0); chk("rdy_count", count, 1);
    step();
    chk("exec_iss_valid", iss_valid, 0); chk("exec_count", count, 1);
    cdb(4'd0, 9'd8); step(); idle();
    chk("done_count", count, 0); chk("done_empty", empty, 1);

    // Dependency wakeup over the CDB
    iss_ready = 1'b0;
    set_disp(OP_SUB, 3'd4, 9'd0, 9'd4, 4'd7, NT); step(); idle();
    chk("wake_pend_valid", iss_valid, 0); chk("wake_pend_count", count, 1);
    cdb(4'd7, 9'd9); step(); idle();
    chk("wake_iss_valid", iss_valid, 1); chk("wake_iss_a", iss_a, 9);
    chk("wake_iss_b", iss_b, 4); chk("wake_iss_op", iss_op, OP_SUB);
    iss_ready = 1'b1; step(); iss_ready = 1'b0;
    cdb(4'd0, 9'd1); step(); idle();

    // Same-cycle bypass at dispatch
    set_disp(OP_SOM, 3'd1, 9'd1, 9'd0, NT, 4'd5); cdb(4'd5, 9'd12); step(); idle();
    chk("byp_iss_valid", iss_valid, 1); chk("byp_iss_b", iss_b, 12); chk("byp_iss_a", iss_a, 1);
    iss_ready = 1'b1; step(); iss_ready = 1'b0;
    cdb(4'd0, 9'd0); step(); idle();

    // Fill the station, hold a fourth dispatch, then free entry 1
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_SOM, 3'(i), 9'(10 + i), 9'd1, 4'd7, NT); step();
    end
    chk("full_full", full, 1); chk("full_disp_ready", disp_ready, 0); chk("full_count", count, 3);
    set_disp(OP_SUB, 3'd7, 9'd99, 9'd99, NT, NT); step(); idle();
    chk("held_count", count, 3); chk("held_iss_valid", iss_valid, 0);
    cdb(4'd7, 9'd20); step(); idle();
    chk("fill_wake_tag", iss_tag, 0); chk("fill_wake_a", iss_a, 20);
    iss_ready = 1'b1; step(); step(); step(); iss_ready = 1'b0;
    chk("allexec_valid", iss_valid, 0); chk("allexec_full", full, 1);
    cdb(4'd1, 9'd0); step(); idle();
    chk("free1_disp_ready", disp_ready, 1); chk("free1_disp_tag", disp_tag, 1);
    chk("free1_count", count, 2); chk("free1_full", full, 0);
    cdb(4'd0, 9'd0); step(); cdb(4'd2, 9'd0); step(); idle();
    chk("drain_count", count, 0);

    // Age order: younger ready B goes before A, then A after wakeup
    set_disp(OP_SOM, 3'd0, 9'd0, 9'd2, 4'd7, NT); step();
    set_disp(OP_SUB, 3'd1, 9'd6, 9'd1, NT, NT); iss_ready = 1'b1; step(); idle();
    chk("age_b_tag", iss_tag, 1); chk("age_b_a", iss_a, 6);
    cdb(4'd7, 9'd30); step(); idle();
    chk("age_a_tag", iss_tag, 0); chk("age_a_a", iss_a, 30);
    step(); iss_ready = 1'b0;
    cdb(4'd1, 9'd0); step(); cdb(4'd0, 9'd0); step(); idle();

    // Age order independent of slot index
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_SOM, 3'(i), 9'(40 + i), 9'd0, NT, NT); step();
    end
    idle();
    iss_ready = 1'b1; step(); iss_ready = 1'b0;
    cdb(4'd0, 9'd0); step(); idle();
    set_disp(OP_SOM, 3'd3, 9'd50, 9'd0, NT, NT); step(); idle();
    chk("ord_q_tag", iss_tag, 1); chk("ord_q_a", iss_a, 41);
    iss_ready = 1'b1; step();
    chk("ord_r_tag", iss_tag, 2); chk("ord_r_a", iss_a, 42);
    step();
    chk("ord_s_tag", iss_tag, 0); chk("ord_s_a", iss_a, 50);
    step(); iss_ready = 1'b0;
    chk("ord_exec_valid", iss_valid, 0); chk("ord_exec_count", count, 3);

    // Flush with entries in EXEC, beating a same-cycle dispatch
    flush = 1'b1; set_disp(OP_SOM, 3'd0, 9'd1, 9'd1, NT, NT); step(); idle();
    chk("flush_count", count, 0); chk("flush_empty", empty, 1); chk("flush_iss_valid", iss_valid, 0);
    set_disp(OP_SOM, 3'd5, 9'd7, 9'd8, NT, NT); step();
    set_disp(OP_SUB, 3'd6, 9'd9, 9'd3, NT, NT); step(); idle();
    cdb(4'd1, 9'd0); step(); cdb(4'd2, 9'd0); step(); idle();
    chk("stale_cdb_count", count, 2); chk("stale_cdb_tag", iss_tag, 0);

    // Reset with two entries in EXEC; reset outranks flush and CDB
    iss_ready = 1'b1; step(); step();
    chk("pre_rst_count", count, 2); chk("pre_rst_valid", iss_valid, 0);
    rst_n = 1'b0; flush = 1'b1; cdb(4'd0, 9'd0); step(); rst_n = 1'b1; idle();
    chk("mid_rst_count", count, 0); chk("mid_rst_empty", empty, 1); chk("mid_rst_disp_tag", disp_tag, 0);
    cdb(4'd1, 9'd0); step(); idle();
    chk("post_rst_count", count, 0);

    // Dispatch, issue, bypass capture and completion in the same cycle
    iss_ready = 1'b0;
    set_disp(OP_SOM, 3'd1, 9'd11, 9'd1, NT, NT); step();
    set_disp(OP_SUB, 3'd2, 9'd22, 9'd2, NT, NT); iss_ready = 1'b1; step(); idle();
    set_disp(OP_SOM, 3'd3, 9'd0, 9'd4, 4'd0, NT); cdb(4'd0, 9'd33); step(); idle(); iss_ready = 1'b0;
    chk("conc_count", count, 2); chk("conc_iss_valid", iss_valid, 1);
    chk("conc_iss_tag", iss_tag, 2); chk("conc_iss_a", iss_a, 33); chk("conc_disp_tag", disp_tag, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
